// File: rtl/beta_csr_pkg.sv
// Shared CSR-side types and constants for the trap control unit and its priority encoder.
package beta_csr_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [4:0] EXC_FETCH_MIS = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL   = 5'd2;
  localparam logic [4:0] EXC_EBREAK    = 5'd3;
  localparam logic [4:0] EXC_LOAD_MIS  = 5'd4;
  localparam logic [4:0] EXC_STORE_MIS = 5'd6;
  localparam logic [4:0] EXC_ECALL_U   = 5'd8;
  localparam logic [4:0] EXC_ECALL_M   = 5'd11;

  localparam logic [4:0] INT_MSI = 5'd3;
  localparam logic [4:0] INT_MTI = 5'd7;
  localparam logic [4:0] INT_MEI = 5'd11;

  localparam int EXC_BIT_FETCH_MIS = 0;
  localparam int EXC_BIT_ILLEGAL   = 1;
  localparam int EXC_BIT_EBREAK    = 2;
  localparam int EXC_BIT_ECALL     = 3;
  localparam int EXC_BIT_LOAD_MIS  = 4;
  localparam int EXC_BIT_STORE_MIS = 5;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    TCU_IDLE,
    TCU_CSR_WR,
    TCU_REDIRECT
  } tcu_state_t;

  typedef enum logic [1:0] {
    TVAL_ZERO,
    TVAL_ADDR,
    TVAL_INSTR
  } tval_sel_t;

  typedef struct packed {
    logic                mie;
    logic                mpie;
    logic [1:0]          mpp;
    logic [CSR_XLEN-1:0] mtvec;
    logic [CSR_XLEN-1:0] mepc;
    logic [CSR_XLEN-1:0] mcause;
    logic [CSR_XLEN-1:0] mtval;
    logic                ext_pend;
    logic                ext_en;
    logic                tim_pend;
    logic                tim_en;
    logic                soft_pend;
    logic                soft_en;
  } csr_ctrl_t;

endpackage

// File: rtl/beta_trap_prio_enc.sv
// Combinational trap arbiter: exceptions over enabled interrupts over MRET.
module beta_trap_prio_enc
  import beta_csr_pkg::*;
(
  input  logic [5:0] exc,
  input  logic [2:0] irq,
  input  logic       mret,
  input  logic [1:0] priv_lvl,
  output logic       evt_valid,
  output logic       is_irq,
  output logic       is_mret,
  output logic [4:0] cause,
  output tval_sel_t  tval_sel
);

  // irq is already masked by MIE and ordered {MEI, MSI, MTI}
  always_comb begin
    evt_valid = 1'b0;
    is_irq    = 1'b0;
    is_mret   = 1'b0;
    cause     = '0;
    tval_sel  = TVAL_ZERO;
    if (|exc) begin
      evt_valid = 1'b1;
      if (exc[EXC_BIT_FETCH_MIS]) begin
        cause    = EXC_FETCH_MIS;
        tval_sel = TVAL_ADDR;
      end else if (exc[EXC_BIT_ILLEGAL]) begin
        cause    = EXC_ILLEGAL;
        tval_sel = TVAL_INSTR;
      end else if (exc[EXC_BIT_EBREAK]) begin
        cause = EXC_EBREAK;
      end else if (exc[EXC_BIT_ECALL]) begin
        cause = (priv_lvl == 2'b11) ? EXC_ECALL_M : EXC_ECALL_U;
      end else if (exc[EXC_BIT_LOAD_MIS]) begin
        cause    = EXC_LOAD_MIS;
        tval_sel = TVAL_ADDR;
      end else begin
        cause    = EXC_STORE_MIS;
        tval_sel = TVAL_ADDR;
      end
    end else if (|irq) begin
      evt_valid = 1'b1;
      is_irq    = 1'b1;
      if (irq[2])      cause = INT_MEI;
      else if (irq[1]) cause = INT_MSI;
      else             cause = INT_MTI;
    end else if (mret) begin
      evt_valid = 1'b1;
      is_mret   = 1'b1;
    end
  end

endmodule

// File: rtl/beta_trap_ctrl_unit.sv
// Trap control unit: captures trap/MRET CSR updates at retire, strobes the regfile, then redirects fetch.
module beta_trap_ctrl_unit
  import beta_csr_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 retire_valid_i,
  input  logic [AddrWidth-1:0] pc_i,
  input  logic [AddrWidth-1:0] next_pc_i,
  input  logic [31:0]          instr_i,
  input  logic [AddrWidth-1:0] fault_addr_i,
  input  logic [5:0]           exc_i,
  input  logic                 mret_i,
  input  logic [1:0]           priv_lvl_i,
  input  csr_ctrl_t            csr_control_i,
  output logic                 tcu_csr_we_o,
  output logic [DataWidth-1:0] csr_mcause_o,
  output logic [DataWidth-1:0] csr_mtval_o,
  output logic [AddrWidth-1:0] csr_mepc_o,
  output logic [2:0]           csr_trap_state_o,
  output logic                 redirect_valid_o,
  output logic [AddrWidth-1:0] redirect_pc_o,
  input  logic                 redirect_ready_i,
  output logic                 flush_o,
  output logic                 busy_o
);

  tcu_state_t state_q, state_d;

  logic [2:0]     irq;
  logic           evt_valid, is_irq, is_mret, evt_fire;
  logic [4:0]     cause;
  tval_sel_t      tval_sel;

  logic [DataWidth-1:0] mcause_d, mtval_d, mcause_q, mtval_q;
  logic [AddrWidth-1:0] mepc_d, target_d, mepc_q, target_q;
  logic [2:0]           tstate_d, tstate_q;

  logic unused_mpp;
  assign unused_mpp = ^csr_control_i.mpp;

  assign irq = {3{csr_control_i.mie}} &
               {csr_control_i.ext_pend  & csr_control_i.ext_en,
                csr_control_i.soft_pend & csr_control_i.soft_en,
                csr_control_i.tim_pend  & csr_control_i.tim_en};

  beta_trap_prio_enc u_prio (
    .exc       (exc_i),
    .irq       (irq),
    .mret      (mret_i),
    .priv_lvl  (priv_lvl_i),
    .evt_valid (evt_valid),
    .is_irq    (is_irq),
    .is_mret   (is_mret),
    .cause     (cause),
    .tval_sel  (tval_sel)
  );

  assign evt_fire = (state_q == TCU_IDLE) && retire_valid_i && evt_valid;

  always_comb begin
    mcause_d                = '0;
    mcause_d[4:0]           = cause;
    mcause_d[DataWidth-1]   = is_irq;
    case (tval_sel)
      TVAL_ADDR:  mtval_d = DataWidth'(fault_addr_i);
      TVAL_INSTR: mtval_d = DataWidth'(instr_i);
      default:    mtval_d = '0;
    endcase
    mepc_d   = is_irq ? next_pc_i : pc_i;
    tstate_d = {1'b0, csr_control_i.mie, 1'b1};
    target_d = AddrWidth'(csr_control_i.mtvec) & ~AddrWidth'(3);
    if (is_irq && (csr_control_i.mtvec[1:0] == MTVEC_VECTORED))
      target_d = target_d + AddrWidth'({cause, 2'b00});
    // MRET rewrites the same CSRs, so the current values pass straight through
    if (is_mret) begin
      mcause_d = DataWidth'(csr_control_i.mcause);
      mtval_d  = DataWidth'(csr_control_i.mtval);
      mepc_d   = AddrWidth'(csr_control_i.mepc);
      tstate_d = {csr_control_i.mpie, 1'b1, 1'b0};
      target_d = AddrWidth'(csr_control_i.mepc);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TCU_IDLE:     if (evt_fire) state_d = TCU_CSR_WR;
      TCU_CSR_WR:   state_d = TCU_REDIRECT;
      TCU_REDIRECT: if (redirect_ready_i) state_d = TCU_IDLE;
      default:      state_d = TCU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= TCU_IDLE;
      mcause_q <= '0;
      mtval_q  <= '0;
      mepc_q   <= '0;
      tstate_q <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (evt_fire) begin
        mcause_q <= mcause_d;
        mtval_q  <= mtval_d;
        mepc_q   <= mepc_d;
        tstate_q <= tstate_d;
        target_q <= target_d;
      end
    end
  end

  assign tcu_csr_we_o     = (state_q == TCU_CSR_WR);
  assign redirect_valid_o = (state_q == TCU_REDIRECT);
  assign busy_o           = (state_q != TCU_IDLE);
  assign flush_o          = busy_o || evt_fire;
  assign csr_mcause_o     = mcause_q;
  assign csr_mtval_o      = mtval_q;
  assign csr_mepc_o       = mepc_q;
  assign csr_trap_state_o = tstate_q;
  assign redirect_pc_o    = target_q;

endmodule

// File: doc/beta_trap_ctrl_unit.md
Name: beta_trap_ctrl_unit

Overview:
- Trap control unit (TCU): the initiator side of the CSR regfile's trap-update interface.
- Arbitrates synchronous exceptions, enabled pending interrupts and MRET at the retire boundary.
- Computes mcause/mtval/mepc and the next {MIE,MPIE,MPP} state, then pulses the CSR write enable.
- Redirects fetch to the handler address or to mepc through a valid/ready handshake.

Parameters:
- DataWidth, 32, width of data and cause/tval lines
- AddrWidth, 32, width of PC/address lines

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- retire_valid_i  in  1  instruction at retire boundary this cycle
- pc_i  in  AddrWidth  PC of retiring instruction
- next_pc_i  in  AddrWidth  sequential successor PC
- instr_i  in  32  retiring instruction word
- fault_addr_i  in  AddrWidth  misaligned load/store/fetch address
- exc_i  in  6  {store_mis, load_mis, ecall, ebreak, illegal, fetch_mis}
- mret_i  in  1  retiring instruction is MRET
- priv_lvl_i  in  2  current privilege (2'b11 = M, 2'b00 = U)
- csr_control_i  in  csr_ctrl_t  mie, mpie, mpp, mtvec, mepc, mcause, mtval, {pend,en} for ext/tim/soft
- tcu_csr_we_o  out  1  one-cycle CSR trap-update strobe
- csr_mcause_o  out  DataWidth  new mcause
- csr_mtval_o  out  DataWidth  new mtval
- csr_mepc_o  out  AddrWidth  new mepc
- csr_trap_state_o  out  3  new {MIE,MPIE,MPP}
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  AddrWidth  redirect target
- redirect_ready_i  in  1  fetch accepts redirect
- flush_o  out  1  flush younger pipeline stages
- busy_o  out  1  TCU not idle; datapath must stall retire

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - State returns to IDLE, including mid-operation; any pending redirect is dropped.
  - All outputs are 0.
- FSM states: IDLE, CSR_WR, REDIRECT.
- IDLE: an event is evaluated only when retire_valid_i=1. Priority, highest first:
  - Exception, any exc_i bit set. Order within exceptions: fetch_mis (cause 0), illegal (2), ebreak (3), ecall (8 if priv_lvl_i=00, 11 if 11), load_mis (4), store_mis (6).
  - Interrupt, only if csr mie=1 and some pend&en pair is set. Order within interrupts: MEI (11), MSI (3), MTI (7). Cause bit DataWidth-1 = 1.
  - MRET.
  - A lower-priority event in the same cycle is discarded. The datapath re-presents it later if it is still valid.
- On event: all output registers are captured and the FSM goes to CSR_WR. flush_o=1 in the event cycle (combinational) and while busy.
- Exception or interrupt values:
  - mepc = pc_i for an exception, next_pc_i for an interrupt.
  - mtval = fault_addr_i for fetch/load/store misaligned; instr_i for illegal; 0 otherwise.
  - trap_state = {0, old MIE, 1}.
  - target = mtvec & ~3. If mtvec[1:0]=01 and the event is an interrupt, target += 4*cause[4:0].
- MRET values:
  - mcause, mtval and mepc are passed through from csr_control_i unchanged, because the regfile rewrites all three.
  - trap_state = {old MPIE, 1, 0}.
  - target = csr mepc.
- CSR_WR: tcu_csr_we_o=1 for exactly one cycle, then REDIRECT.
- REDIRECT: redirect_valid_o=1 with stable redirect_pc_o until redirect_ready_i=1, then IDLE. If ready is already high on entry, REDIRECT lasts 1 cycle.
- Latency: event at cycle N → we at N+1 → redirect_valid from N+2.
- busy_o=1 in CSR_WR and REDIRECT. Inputs are ignored while busy_o=1.
- csr_*_o hold their last values in IDLE; they are qualified only by tcu_csr_we_o.
- Addition is modulo 2^AddrWidth; no overflow detection.

Decomposition:
- Add to beta_csr_pkg:
  - cause-code constants (EXC_*, INT_*)
  - exc_i bit indices
  - tcu_state_t enum
  - MTVEC mode constants
- Sub-module beta_trap_prio_enc: purely combinational. Takes exc_i, masked interrupts, mret_i and priv_lvl_i; outputs event-valid, interrupt flag, cause and tval-select.

Test Plan:
- Illegal instr: exc_i=000010, pc_i=0x100, instr_i=0xFFFFFFFF → we at N+1 with mcause=2, mtval=0xFFFFFFFF, mepc=0x100, trap_state={0,MIE,1}; redirect to mtvec base at N+2.
- Timer interrupt, vectored: mtvec=0x0000_0201, mie=1, tim={1,1}, next_pc_i=0x204 → mcause=0x8000_0007, mepc=0x204, redirect_pc=0x21C.
- Interrupt gating: mie=0 with ext={1,1} → no event. Same with mie=1 and ecall in U → ecall wins, mcause=8.
- MRET: mepc=0x400, mpie=1, mcause=0xB → trap_state=3'b110, mcause_o=0xB passthrough, redirect_pc=0x400.
- Handshake/reset: hold redirect_ready_i=0 for 3 cycles → valid and PC stable, busy_o=1. Then rst_i=1 mid-REDIRECT → next cycle all outputs 0, state IDLE.
- Multi-exception priority: exc_i=110001, fault_addr=0x3 → mcause=0, mtval=0x3.
